// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - packet-sticky 1:2 stream demultiplexer with two-entry per-channel FIFOs
// Channel select is latched at packet start and held until the last beat is accepted.

module stream_demux_fifo #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // With one entry the new beat replaces the departing head directly.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

module stream_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             i_valid,
    input  logic             i_last,
    input  logic             s,
    output logic             i_ready,
    output logic [WIDTH-1:0] o0,
    output logic             o0_valid,
    output logic             o0_last,
    input  logic             o0_ready,
    output logic [WIDTH-1:0] o1,
    output logic             o1_valid,
    output logic             o1_last,
    input  logic             o1_ready,
    output logic [7:0]       pkt_cnt0,
    output logic [7:0]       pkt_cnt1
);

    typedef enum logic [1:0] {IDLE, ROUTE0, ROUTE1} state_t;

    state_t       state, state_nxt;
    logic         target;
    logic         accept;
    logic         push0, push1, pop0, pop1;
    logic [1:0]   count0, count1;
    logic [WIDTH:0] head0, head1;

    always_comb begin
        target = 1'b0;
        case (state)
            IDLE:    target = s;
            ROUTE0:  target = 1'b0;
            ROUTE1:  target = 1'b1;
            default: target = 1'b0;
        endcase
    end

    // A popping full FIFO still reports not-ready; no same-cycle pass-through.
    assign i_ready = target ? (count1 < 2'd2) : (count0 < 2'd2);
    assign accept  = i_valid & i_ready;
    assign push0   = accept & ~target;
    assign push1   = accept & target;
    assign pop0    = o0_valid & o0_ready;
    assign pop1    = o1_valid & o1_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !i_last) state_nxt = s ? ROUTE1 : ROUTE0;
            end
            ROUTE0, ROUTE1: begin
                if (accept && i_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= 8'd0;
            pkt_cnt1 <= 8'd0;
        end else begin
            if (push0 && i_last) pkt_cnt0 <= pkt_cnt0 + 8'd1;
            if (push1 && i_last) pkt_cnt1 <= pkt_cnt1 + 8'd1;
        end
    end

    stream_demux_fifo #(.DW(WIDTH + 1)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .pop   (pop0),
        .din   ({i_last, i}),
        .head  (head0),
        .count (count0)
    );

    stream_demux_fifo #(.DW(WIDTH + 1)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .pop   (pop1),
        .din   ({i_last, i}),
        .head  (head1),
        .count (count1)
    );

    assign o0       = head0[WIDTH-1:0];
    assign o0_last  = head0[WIDTH];
    assign o0_valid = (count0 != 2'd0);
    assign o1       = head1[WIDTH-1:0];
    assign o1_last  = head1[WIDTH];
    assign o1_valid = (count1 != 2'd0);

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux
module tb_stream_demux;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i;
    logic       i_valid, i_last, s, i_ready;
    logic [7:0] o0, o1;
    logic       o0_valid, o1_valid, o0_last, o1_last, o0_ready, o1_ready;
    logic [7:0] pkt_cnt0, pkt_cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_last(i_last), .s(s),
        .i_ready(i_ready),
        .o0(o0), .o0_valid(o0_valid), .o0_last(o0_last), .o0_ready(o0_ready),
        .o1(o1), .o1_valid(o1_valid), .o1_last(o1_last), .o1_ready(o1_ready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    typedef struct {
        logic       v, s;
        logic [7:0] d;
        logic       l, r0, r1;
        logic       e_ir, e_o0v;
        logic [7:0] e_o0;
        logic       e_o1v;
        logic [7:0] e_o1;
        logic [7:0] e_c0, e_c1;
    } vec_t;

    vec_t tbl[18];

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic sel, input logic [7:0] d,
                         input logic l, input logic r0, input logic r1);
        i_valid = v; s = sel; i = d; i_last = l; o0_ready = r0; o1_ready = r1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(H, L, 8'hEE, H, L, L);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(L, L, 8'h00, L, L, L);
    endtask

    initial begin
        // single beat, sticky select, backpressure, independent channels
        tbl[0]  = '{H, H, 8'hA5, H, L, H,  H, L, 8'h00, H, 8'hA5, 8'd0, 8'd1};
        tbl[1]  = '{L, L, 8'h00, L, L, H,  H, L, 8'h00, L, 8'h00, 8'd0, 8'd1};
        tbl[2]  = '{H, L, 8'h11, L, L, L,  H, H, 8'h11, L, 8'h00, 8'd0, 8'd1};
        tbl[3]  = '{H, H, 8'h22, L, H, L,  H, H, 8'h22, L, 8'h00, 8'd0, 8'd1};
        tbl[4]  = '{H, H, 8'h33, H, H, L,  H, H, 8'h33, L, 8'h00, 8'd1, 8'd1};
        tbl[5]  = '{L, L, 8'h00, L, H, L,  H, L, 8'h00, L, 8'h00, 8'd1, 8'd1};
        tbl[6]  = '{H, L, 8'h01, L, L, L,  H, H, 8'h01, L, 8'h00, 8'd1, 8'd1};
        tbl[7]  = '{H, L, 8'h02, L, L, L,  H, H, 8'h01, L, 8'h00, 8'd1, 8'd1};
        tbl[8]  = '{H, L, 8'h03, L, L, L,  L, H, 8'h01, L, 8'h00, 8'd1, 8'd1};
        tbl[9]  = '{H, L, 8'h03, L, H, L,  L, H, 8'h02, L, 8'h00, 8'd1, 8'd1};
        tbl[10] = '{H, L, 8'h03, L, L, L,  H, H, 8'h02, L, 8'h00, 8'd1, 8'd1};
        tbl[11] = '{H, L, 8'h04, H, L, L,  L, H, 8'h02, L, 8'h00, 8'd1, 8'd1};
        tbl[12] = '{H, L, 8'h04, H, H, L,  L, H, 8'h03, L, 8'h00, 8'd1, 8'd1};
        tbl[13] = '{H, L, 8'h04, H, L, L,  H, H, 8'h03, L, 8'h00, 8'd2, 8'd1};
        tbl[14] = '{H, H, 8'hB1, L, L, L,  H, H, 8'h03, H, 8'hB1, 8'd2, 8'd1};
        tbl[15] = '{H, L, 8'hB2, H, L, H,  H, H, 8'h03, H, 8'hB2, 8'd2, 8'd2};
        tbl[16] = '{L, L, 8'h00, L, H, H,  L, H, 8'h04, L, 8'h00, 8'd2, 8'd2};
        tbl[17] = '{L, L, 8'h00, L, H, L,  H, L, 8'h00, L, 8'h00, 8'd2, 8'd2};

        do_reset();
        #1;
        chk("rst_o0_valid", o0_valid, 0);
        chk("rst_o1_valid", o1_valid, 0);
        chk("rst_o0", {o0_last, o0}, 0);
        chk("rst_o1", {o1_last, o1}, 0);
        chk("rst_cnt", {pkt_cnt0, pkt_cnt1}, 0);
        chk("rst_i_ready", i_ready, 1);

        for (int k = 0; k < 18; k++) begin
            drive(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].l, tbl[k].r0, tbl[k].r1);
            #1;
            chk($sformatf("vec%0d_i_ready", k), i_ready, tbl[k].e_ir);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_o0_valid", k), o0_valid, tbl[k].e_o0v);
            if (tbl[k].e_o0v) chk($sformatf("vec%0d_o0", k), o0, tbl[k].e_o0);
            chk($sformatf("vec%0d_o1_valid", k), o1_valid, tbl[k].e_o1v);
            if (tbl[k].e_o1v) chk($sformatf("vec%0d_o1", k), o1, tbl[k].e_o1);
            chk($sformatf("vec%0d_cnt0", k), pkt_cnt0, tbl[k].e_c0);
            chk($sformatf("vec%0d_cnt1", k), pkt_cnt1, tbl[k].e_c1);
            @(negedge clk);
        end

        // counter wrap on channel 0
        do_reset();
        for (int k = 0; k < 255; k++) begin
            drive(H, L, k[7:0], H, H, L);
            @(posedge clk);
            @(negedge clk);
        end
        chk("wrap_cnt0_255", pkt_cnt0, 255);
        @(posedge clk);
        #1;
        chk("wrap_cnt0_0", pkt_cnt0, 0);
        chk("wrap_cnt1", pkt_cnt1, 0);
        @(negedge clk);

        // reset in the middle of a channel-1 packet
        do_reset();
        drive(H, H, 8'hC1, L, L, L);
        @(posedge clk); @(negedge clk);
        drive(H, H, 8'hC2, L, L, L);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        drive(H, L, 8'hC3, H, L, L);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        drive(L, H, 8'h00, L, L, L);
        #1;
        chk("midrst_o1_valid", o1_valid, 0);
        chk("midrst_o0_valid", o0_valid, 0);
        chk("midrst_cnt1", pkt_cnt1, 0);
        @(negedge clk);
        drive(H, L, 8'hD0, H, L, L);
        @(posedge clk);
        #1;
        chk("midrst_next_o0_valid", o0_valid, 1);
        chk("midrst_next_o0", {o0_last, o0}, {1'b1, 8'hD0});
        chk("midrst_next_o1_valid", o1_valid, 0);
        chk("midrst_next_cnt", {pkt_cnt0, pkt_cnt1}, {8'd1, 8'd0});
        @(negedge clk);

        // randomized traffic against a queue-based packet model
        do_reset();
        q0.delete();
        q1.delete();
        begin
            int route;
            int c0, c1;
            logic rr, vv, ss, ll, r0, r1, exp_ir, tgt;
            logic [7:0] dd;
            route = -1; c0 = 0; c1 = 0;
            for (int n = 0; n < 3000; n++) begin
                rr = ($urandom_range(0, 149) == 0);
                vv = ($urandom_range(0, 3) != 0);
                ss = $urandom_range(0, 1) == 1;
                ll = ($urandom_range(0, 3) == 0);
                dd = 8'($urandom_range(0, 255));
                r0 = ($urandom_range(0, 9) < 6);
                r1 = ($urandom_range(0, 9) < 4);
                rst = rr;
                drive(vv, ss, dd, ll, r0, r1);
                #1;
                tgt = (route < 0) ? ss : (route == 1);
                exp_ir = tgt ? (q1.size() < 2) : (q0.size() < 2);
                if (!rr) chk("rnd_i_ready", i_ready, exp_ir);
                chk("rnd_o0_valid", o0_valid, q0.size() != 0);
                chk("rnd_o1_valid", o1_valid, q1.size() != 0);
                if (q0.size() != 0) chk("rnd_o0", {o0_last, o0}, q0[0]);
                if (q1.size() != 0) chk("rnd_o1", {o1_last, o1}, q1[0]);
                chk("rnd_cnt", {pkt_cnt0, pkt_cnt1}, {8'(c0), 8'(c1)});
                @(posedge clk);
                if (rr) begin
                    q0.delete(); q1.delete();
                    route = -1; c0 = 0; c1 = 0;
                end else begin
                    if (q0.size() != 0 && r0) void'(q0.pop_front());
                    if (q1.size() != 0 && r1) void'(q1.pop_front());
                    if (vv && exp_ir) begin
                        if (tgt) q1.push_back({ll, dd});
                        else     q0.push_back({ll, dd});
                        if (ll) begin
                            if (tgt) c1 = (c1 + 1) % 256;
                            else     c0 = (c0 + 1) % 256;
                            route = -1;
                        end else begin
                            route = tgt ? 1 : 0;
                        end
                    end
                end
                @(negedge clk);
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
